ones_pattern_gen: RTL and testbench

Sequential generator that enumerates, in increasing numeric order, every WIDTH-bit word containing exactly k set bits. It delivers one word per accepted transfer over a valid/ready stream. It is the inverse companion of `count_ones`: `count_ones` maps a word to its population count, and this block maps a population count to all words that have it. It serves as a stimulus source for popcount and weight-based datapaths and for exhaustive self-checking benches.

---
 rtl/ones_gen_pkg.sv | 21 ++
 rtl/ones_next_word.sv | 41 ++++
 rtl/ones_pattern_gen.sv | 99 +++++++++
 tb/tb_ones_pattern_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/ones_gen_pkg.sv
// rtl/ones_gen_pkg.sv - shared state encoding, default width and word-mask helpers
package ones_gen_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Smallest word with n ones: ones packed at the bottom.
    function automatic logic [31:0] first_word_mask(input int unsigned n);
        return (32'd1 << n) - 32'd1;
    endfunction

    // Largest word with n ones in a width-bit field: ones packed at the top.
    function automatic logic [31:0] last_word_mask(input int unsigned width, input int unsigned n);
        return first_word_mask(n) << (width - n);
    endfunction

endpackage

// File: rtl/ones_next_word.sv
// rtl/ones_next_word.sv - combinational next-larger word with equal popcount
module ones_next_word
    import ones_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] x_i,
    output logic [WIDTH-1:0] y_o
);

    localparam int RW = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] lowest;
    logic [WIDTH-1:0] ripple;
    logic [WIDTH-1:0] changed;
    logic [WIDTH-1:0] low_ones;
    logic [RW-1:0]    changed_cnt;

    always_comb begin
        lowest  = x_i & (~x_i + 1'b1);
        // Adding the lowest one clears the run of length L and sets bit p+L.
        ripple  = x_i + lowest;
        changed = x_i ^ ripple;

        changed_cnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            changed_cnt = changed_cnt + RW'(changed[i]);
        end

        // changed holds L+1 ones; L-1 of them are refilled at the bottom.
        low_ones = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i + 2 < int'(changed_cnt)) begin
                low_ones[i] = 1'b1;
            end
        end

        y_o = ripple | low_ones;
    end

endmodule

// File: rtl/ones_pattern_gen.sv
// rtl/ones_pattern_gen.sv - streams every WIDTH-bit word with exactly k ones in increasing order
module ones_pattern_gen
    import ones_gen_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CW-1:0]    k,
    output logic             busy,
    output logic             err,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_index,
    output logic             out_last
);

    state_t           state_q, state_d;
    logic [CW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] index_q, index_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] next_word;
    logic [31:0]      first_w;
    logic [31:0]      last_w;
    logic             is_last;

    ones_next_word #(.WIDTH(WIDTH)) u_next (
        .x_i (data_q),
        .y_o (next_word)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            data_q  <= '0;
            index_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            data_q  <= data_d;
            index_q <= index_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        data_d  = data_q;
        index_d = index_q;
        err_d   = 1'b0;

        first_w = first_word_mask(int'(k));
        last_w  = last_word_mask(WIDTH, int'(k_q));
        // Gated by state so the idle value of data_q never reads as a last word.
        is_last = (state_q == ST_EMIT) && (data_q == last_w[WIDTH-1:0]);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (int'(k) > WIDTH) begin
                        err_d = 1'b1;
                    end else begin
                        k_d     = k;
                        data_d  = first_w[WIDTH-1:0];
                        index_d = '0;
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (out_ready) begin
                    if (is_last) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d  = next_word;
                        index_d = index_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy      = (state_q == ST_EMIT);
    assign out_valid = (state_q == ST_EMIT);
    assign err       = err_q;
    assign out_data  = data_q;
    assign out_index = index_q;
    assign out_last  = is_last;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// tb/tb_ones_pattern_gen.sv - directed table and sequence checks for ones_pattern_gen
module tb_ones_pattern_gen;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] k;
    logic          busy;
    logic          err;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [W-1:0]  out_index;
    logic          out_last;

    int errors = 0;
    int checks = 0;

    ones_pattern_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .k         (k),
        .busy      (busy),
        .err       (err),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int kk;
        bit exp_err;
        int exp_len;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference enumeration: scan upward for the next value with kk ones.
    function automatic int next_ref(input int cur, input int kk);
        for (int v = cur + 1; v < (1 << W); v++) begin
            if ($countones(v) == kk) return v;
        end
        return -1;
    endfunction

    task automatic chk_idle_zero(input string tag);
        chk({tag, " busy"},      32'(busy),      0);
        chk({tag, " err"},       32'(err),       0);
        chk({tag, " out_valid"}, 32'(out_valid), 0);
        chk({tag, " out_data"},  32'(out_data),  0);
        chk({tag, " out_index"}, 32'(out_index), 0);
        chk({tag, " out_last"},  32'(out_last),  0);
    endtask

    // n = words transferred, or -1 when the run was cut by reset.
    task automatic run_seq(input int kk, input int stall_at, input int rst_at, input bit poke,
                           output int n, output int firstw, output int lastw);
        int  exp_w;
        int  stalls;
        bit  done;
        bit  was_last;
        n = 0; firstw = -1; lastw = -1; stalls = 0; done = 0;
        out_ready = 1'b1;
        start = 1'b1;
        k = CW'(kk);
        tick();
        start = 1'b0;
        exp_w = next_ref(-1, kk);
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (!out_valid) begin
                chk("out_valid during sequence", 32'(out_valid), 1);
                done = 1;
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_w));
                chk("out_index", 32'(out_index), 32'(n));
                chk("popcount", 32'($countones(out_data)), 32'(kk));
                chk("busy", 32'(busy), 1);
                if (n == 0) firstw = int'(out_data);
                if (rst_at == n) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    chk_idle_zero("after mid reset");
                    n = -1;
                    done = 1;
                end else if (stall_at == n && stalls < 3) begin
                    out_ready = 1'b0;
                    if (poke) begin
                        start = 1'b1;
                        k = CW'(5);
                    end
                    stalls++;
                    tick();
                    start = 1'b0;
                end else begin
                    out_ready = 1'b1;
                    was_last = out_last;
                    chk("out_last", 32'(out_last), 32'(next_ref(exp_w, kk) < 0));
                    lastw = int'(out_data);
                    n++;
                    tick();
                    if (was_last) begin
                        chk("busy after last", 32'(busy), 0);
                        chk("out_valid after last", 32'(out_valid), 0);
                        done = 1;
                    end else begin
                        exp_w = next_ref(exp_w, kk);
                    end
                end
            end
        end
        if (!done) chk("sequence timeout", 0, 1);
    endtask

    initial begin
        int n, fw, lw;

        tbl[0] = '{2, 0, 28, 'h03, 'hC0};
        tbl[1] = '{0, 0,  1, 'h00, 'h00};
        tbl[2] = '{8, 0,  1, 'hFF, 'hFF};
        tbl[3] = '{9, 1,  0, 0, 0};
        tbl[4] = '{1, 0,  8, 'h01, 'h80};
        tbl[5] = '{4, 0, 70, 'h0F, 'hF0};
        tbl[6] = '{3, 0, 56, 'h07, 'hE0};
        tbl[7] = '{5, 0, 56, 'h1F, 'hF8};
        tbl[8] = '{7, 0,  8, 'h7F, 'hFE};
        tbl[9] = '{15, 1, 0, 0, 0};

        rst = 1'b1; start = 1'b0; k = '0; out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk_idle_zero("reset");

        for (int i = 0; i < 10; i++) begin
            if (tbl[i].exp_err) begin
                start = 1'b1;
                k = CW'(tbl[i].kk);
                tick();
                start = 1'b0;
                chk("err pulse", 32'(err), 1);
                chk("busy on err", 32'(busy), 0);
                chk("out_valid on err", 32'(out_valid), 0);
                tick();
                chk("err cleared", 32'(err), 0);
                chk("busy after err", 32'(busy), 0);
            end else begin
                run_seq(tbl[i].kk, -1, -1, 0, n, fw, lw);
                chk("sequence length", 32'(n), 32'(tbl[i].exp_len));
                chk("first word", 32'(fw), 32'(tbl[i].exp_first));
                chk("last word", 32'(lw), 32'(tbl[i].exp_last));
            end
            tick();
        end

        // Backpressure on the second word of k=4.
        run_seq(4, 1, -1, 0, n, fw, lw);
        chk("stall length", 32'(n), 70);
        chk("stall last word", 32'(lw), 'hF0);
        tick();

        // Reset mid-sequence, then a clean restart.
        run_seq(3, -1, 10, 0, n, fw, lw);
        chk("reset cut", 32'(n), 32'(-1));
        run_seq(3, -1, -1, 0, n, fw, lw);
        chk("restart length", 32'(n), 56);
        chk("restart first word", 32'(fw), 'h07);
        tick();

        // start with k=5 while a k=3 run is stalled must be ignored.
        run_seq(3, 2, -1, 1, n, fw, lw);
        chk("poke length", 32'(n), 56);
        chk("poke last word", 32'(lw), 'hE0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
